// File: rtl/alu_datapath_core.sv
// Accumulator datapath: register file, accumulator A, product-high H, carry/zero flags
// and an ALU with single-cycle ops plus a WIDTH-cycle shift-add multiply.
module alu_datapath_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [AW-1:0]    RegAddr,
  input  logic [3:0]       ALUCode,
  input  logic             Start,
  input  logic             RegWE,
  input  logic             ClrCY,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] H_out,
  output logic             CY,
  output logic             Z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_LDA = 4'd7;
  localparam logic [3:0] OP_RLC = 4'd8;
  localparam logic [3:0] OP_RRC = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] acc_q, high_q;
  logic             cy_q, z_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, prod_hi_q, prod_lo_q;

  logic [WIDTH-1:0] operand;
  logic             idle, single_accept, mul_start, mul_commit;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_a;
  logic             alu_cy, alu_writes;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] next_hi, next_lo;

  assign operand       = rf[RegAddr];
  assign idle          = (state_q == ST_IDLE);
  assign single_accept = idle && Start && (ALUCode != OP_MUL);

  // Single-cycle ALU result; MUL and NOP leave alu_writes low.
  always_comb begin
    alu_a      = acc_q;
    alu_cy     = cy_q;
    alu_writes = 1'b1;
    ext        = '0;
    case (ALUCode)
      OP_ADD: begin
        ext    = {1'b0, acc_q} + {1'b0, operand};
        alu_a  = ext[WIDTH-1:0];
        alu_cy = ext[WIDTH];
      end
      OP_ADC: begin
        ext    = {1'b0, acc_q} + {1'b0, operand} + {{WIDTH{1'b0}}, cy_q};
        alu_a  = ext[WIDTH-1:0];
        alu_cy = ext[WIDTH];
      end
      OP_SUB: begin
        ext    = {1'b0, acc_q} - {1'b0, operand};
        alu_a  = ext[WIDTH-1:0];
        alu_cy = ext[WIDTH];
      end
      OP_SBC: begin
        ext    = {1'b0, acc_q} - {1'b0, operand} - {{WIDTH{1'b0}}, cy_q};
        alu_a  = ext[WIDTH-1:0];
        alu_cy = ext[WIDTH];
      end
      OP_AND:  alu_a = acc_q & operand;
      OP_OR:   alu_a = acc_q | operand;
      OP_XOR:  alu_a = acc_q ^ operand;
      OP_LDA:  alu_a = operand;
      OP_RLC:  {alu_cy, alu_a} = {acc_q, cy_q};
      OP_RRC:  {alu_a, alu_cy} = {cy_q, acc_q};
      default: alu_writes = 1'b0;
    endcase
  end

  // One shift-add step: the multiplier shifts out of prod_lo as product bits shift in.
  assign step_sum = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign next_hi  = step_sum[WIDTH:1];
  assign next_lo  = {step_sum[0], prod_lo_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    mul_start  = 1'b0;
    mul_commit = 1'b0;
    case (state_q)
      ST_IDLE: if (Start && ALUCode == OP_MUL) begin
        state_d   = ST_MUL;
        mul_start = 1'b1;
      end
      ST_MUL: if (cnt_q == '0) begin
        state_d    = ST_IDLE;
        mul_commit = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      acc_q     <= '0;
      high_q    <= '0;
      cy_q      <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (idle && RegWE) rf[RegAddr] <= acc_q;

      if (mul_start) begin
        mcand_q   <= acc_q;
        prod_hi_q <= '0;
        prod_lo_q <= operand;
        cnt_q     <= CW'(WIDTH - 1);
      end else if (!idle) begin
        prod_hi_q <= next_hi;
        prod_lo_q <= next_lo;
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end

      // ClrCY overrides whatever carry the same edge would otherwise produce.
      if (mul_commit) begin
        acc_q  <= next_lo;
        high_q <= next_hi;
        z_q    <= ({next_hi, next_lo} == '0);
        cy_q   <= ClrCY ? 1'b0 : (next_hi != '0);
        done_q <= 1'b1;
      end else if (single_accept) begin
        done_q <= 1'b1;
        if (alu_writes) begin
          acc_q <= alu_a;
          z_q   <= (alu_a == '0);
        end
        cy_q <= ClrCY ? 1'b0 : (alu_writes ? alu_cy : cy_q);
      end else if (ClrCY) begin
        cy_q <= 1'b0;
      end
    end
  end

  assign Busy  = !idle;
  assign Done  = done_q;
  assign A_out = acc_q;
  assign H_out = high_q;
  assign CY    = cy_q;
  assign Z     = z_q;

endmodule
